// File: rtl/eth_field_tracker_pkg.sv
// Shared constants, state encoding and flag bundle for the receive-side
// Ethernet field tracker.
package eth_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int MAC_ADDR_BYTES   = 6;
  localparam int ETHER_TYPE_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DST,
    SRC,
    TYPE,
    PAY,
    DROP
  } fld_state_e;

  typedef struct packed {
    logic preamble_or_sfd;
    logic dst_mac;
    logic src_mac;
    logic ether_type;
    logic payload_or_fcs;
  } fld_flags_t;

  localparam fld_flags_t FLAGS_NONE = '0;

endpackage

// File: rtl/eth_field_tracker_if.sv
// One-hot field classification of the registered byte stream, driven by the
// tracker (master) and consumed by the downstream parser (slave).
interface eth_fields_if;

  logic is_preamble_or_sfd;
  logic is_dst_mac;
  logic is_src_mac;
  logic is_ether_type;
  logic is_payload_or_fcs;

  modport master (
    output is_preamble_or_sfd,
    output is_dst_mac,
    output is_src_mac,
    output is_ether_type,
    output is_payload_or_fcs
  );

  modport slave (
    input is_preamble_or_sfd,
    input is_dst_mac,
    input is_src_mac,
    input is_ether_type,
    input is_payload_or_fcs
  );

endinterface

// File: rtl/eth_field_tracker.sv
// Byte-wide GMII receive framer: classifies every byte of a frame, registers
// it with its field flag, and reports frame end, abort and length.
module eth_field_tracker
  import eth_pkg::*;
#(
  parameter int MAX_PREAMBLE  = 7,
  parameter int MIN_FRAME_LEN = 64,
  parameter int LEN_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [7:0]        data_o,
  output logic              valid_o,
  eth_fields_if.master      fields,
  output logic              sof_o,
  output logic              frame_done_o,
  output logic              frame_abort_o,
  output logic              too_short_o,
  output logic [LEN_W-1:0]  frame_len_o
);

  localparam int PRE_W = (MAX_PREAMBLE < 1) ? 1 : $clog2(MAX_PREAMBLE + 1);

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(MAX_PREAMBLE);
  localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(MIN_FRAME_LEN);
  localparam logic [2:0]       MAC_LAST  = 3'(MAC_ADDR_BYTES - 1);
  localparam logic [2:0]       TYPE_LAST = 3'(ETHER_TYPE_BYTES - 1);

  // Oversized frames stick at all-ones instead of wrapping to a small length.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  fld_state_e       state, state_n;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_n;
  logic [2:0]       field_cnt, field_cnt_n;
  logic [LEN_W-1:0] len_cnt, len_cnt_n;
  logic [2:0]       field_last;

  fld_flags_t       flags_n, flags_p1;
  logic             accept;
  logic             sof_n;
  logic             done_n;
  logic             abort_n;
  logic             too_short_n;
  logic [LEN_W-1:0] frame_len_n;

  assign field_last = (state == TYPE) ? TYPE_LAST : MAC_LAST;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      field_cnt <= '0;
      len_cnt   <= '0;
    end else begin
      state     <= state_n;
      pre_cnt   <= pre_cnt_n;
      field_cnt <= field_cnt_n;
      len_cnt   <= len_cnt_n;
    end
  end

  // ---- next state and per-byte classification ----
  always_comb begin
    state_n     = state;
    pre_cnt_n   = pre_cnt;
    field_cnt_n = field_cnt;
    len_cnt_n   = len_cnt;
    flags_n     = FLAGS_NONE;
    accept      = 1'b0;
    sof_n       = 1'b0;
    done_n      = 1'b0;
    abort_n     = 1'b0;
    frame_len_n = frame_len_o;
    too_short_n = too_short_o;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          // No frame has started yet, so an errored byte here is dropped silently.
          if (rx_err) begin
            state_n = DROP;
          end else begin
            accept                  = 1'b1;
            flags_n.preamble_or_sfd = 1'b1;
            if (rx_data == PREAMBLE_BYTE) begin
              state_n   = PRE;
              pre_cnt_n = PRE_W'(1);
            end else if (rx_data == SFD_BYTE) begin
              state_n     = DST;
              field_cnt_n = '0;
              len_cnt_n   = '0;
            end else begin
              state_n = DROP;
            end
          end
        end
      end

      PRE: begin
        if (!rx_valid) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (rx_err) begin
          state_n = DROP;
          abort_n = 1'b1;
        end else begin
          accept                  = 1'b1;
          flags_n.preamble_or_sfd = 1'b1;
          if (rx_data == PREAMBLE_BYTE && pre_cnt < PRE_MAX) begin
            pre_cnt_n = pre_cnt + PRE_W'(1);
          end else if (rx_data == SFD_BYTE) begin
            state_n     = DST;
            field_cnt_n = '0;
            len_cnt_n   = '0;
          end else begin
            state_n = DROP;
            abort_n = 1'b1;
          end
        end
      end

      DST, SRC, TYPE: begin
        if (!rx_valid) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (rx_err) begin
          state_n = DROP;
          abort_n = 1'b1;
        end else begin
          accept    = 1'b1;
          len_cnt_n = sat_inc(len_cnt);
          sof_n     = (state == DST) && (field_cnt == 3'd0);
          case (state)
            DST:     flags_n.dst_mac    = 1'b1;
            SRC:     flags_n.src_mac    = 1'b1;
            default: flags_n.ether_type = 1'b1;
          endcase
          if (field_cnt == field_last) begin
            field_cnt_n = '0;
            case (state)
              DST:     state_n = SRC;
              SRC:     state_n = TYPE;
              default: state_n = PAY;
            endcase
          end else begin
            field_cnt_n = field_cnt + 3'd1;
          end
        end
      end

      PAY: begin
        if (!rx_valid) begin
          state_n     = IDLE;
          done_n      = 1'b1;
          frame_len_n = len_cnt;
          too_short_n = (len_cnt < LEN_MIN);
        end else if (rx_err) begin
          state_n = DROP;
          abort_n = 1'b1;
        end else begin
          accept                 = 1'b1;
          flags_n.payload_or_fcs = 1'b1;
          len_cnt_n              = sat_inc(len_cnt);
        end
      end

      DROP: begin
        if (!rx_valid) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---- output stage: byte, flags and frame status registered together ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o        <= '0;
      valid_o       <= 1'b0;
      flags_p1      <= FLAGS_NONE;
      sof_o         <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
      too_short_o   <= 1'b0;
      frame_len_o   <= '0;
    end else begin
      data_o        <= rx_data;
      valid_o       <= accept;
      flags_p1      <= flags_n;
      sof_o         <= sof_n;
      frame_done_o  <= done_n;
      frame_abort_o <= abort_n;
      too_short_o   <= too_short_n;
      frame_len_o   <= frame_len_n;
    end
  end

  assign fields.is_preamble_or_sfd = flags_p1.preamble_or_sfd;
  assign fields.is_dst_mac         = flags_p1.dst_mac;
  assign fields.is_src_mac         = flags_p1.src_mac;
  assign fields.is_ether_type      = flags_p1.ether_type;
  assign fields.is_payload_or_fcs  = flags_p1.payload_or_fcs;

endmodule

// File: doc/eth_field_tracker.md
Name: eth_field_tracker

Overview:
- Byte-wide receive-side framer for the 1G MAC, placed directly after the GMII RX capture.
- Tracks the position of each byte in the frame using a state machine and byte counter.
- Drives the eth_fields_if master modport with field flags aligned to a registered copy of the byte stream.
- Reports frame completion, aborts and frame length to the downstream parser.

Parameters:
- MAX_PREAMBLE, 7, maximum number of 0x55 bytes accepted before the SFD.
- MIN_FRAME_LEN, 64, minimum legal length from the first DST byte through the last FCS byte.
- LEN_W, 16, width of the frame length counter.

Ports:
- clk  input  1  system clock, 125 MHz.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  GMII RXD byte.
- rx_valid  input  1  GMII RX_DV.
- rx_err  input  1  GMII RX_ER.
- data_o  output  8  rx_data delayed by one cycle.
- valid_o  output  1  byte valid, aligned to data_o.
- fields  eth_fields_if.master  -  one-hot field flags, aligned to data_o.
- sof_o  output  1  pulses on the first DST byte, aligned to data_o.
- frame_done_o  output  1  one-cycle pulse after a frame ends normally.
- frame_abort_o  output  1  one-cycle pulse when a frame is dropped.
- too_short_o  output  1  qualified by frame_done_o; frame_len_o < MIN_FRAME_LEN.
- frame_len_o  output  LEN_W  byte count from DST through FCS; held until the next frame_done_o.

Behaviour:
- Reset: the clock and reset are as already decided, one clock with asynchronous active-low reset. All outputs and all fields flags are 0, frame_len_o = 0, and the FSM is in IDLE.
- Latency: every byte accepted at edge t appears on data_o/valid_o/fields after edge t+1. Flags are computed from the state before consuming the byte and are registered together with it.
- Flags are one-hot whenever valid_o = 1 and all 0 whenever valid_o = 0. They are also all 0 for bytes consumed in DROP.
- IDLE:
  - rx_valid & 0x55 -> PRE, with pre_cnt = 1.
  - rx_valid & 0xD5 -> DST (SFD with no preamble is accepted).
  - rx_valid & any other byte -> DROP.
  - The byte gets is_preamble_or_sfd.
- PRE:
  - 0x55 with pre_cnt < MAX_PREAMBLE -> stay, pre_cnt++.
  - 0x55 with pre_cnt == MAX_PREAMBLE -> DROP.
  - 0xD5 -> DST.
  - Other byte -> DROP.
  - Flag: is_preamble_or_sfd.
- DST: 6 bytes, is_dst_mac. sof_o is set on the first one. field_cnt counts 0..5, then -> SRC.
- SRC: 6 bytes, is_src_mac, then -> TYPE.
- TYPE: 2 bytes, is_ether_type, then -> PAY.
- PAY: is_payload_or_fcs. Stay while rx_valid.
- Normal end: rx_valid falling while in PAY -> IDLE. frame_done_o pulses on the first cycle valid_o = 0 after the last byte. frame_len_o and too_short_o are updated in the same cycle.
- Truncated frame: rx_valid falling in PRE/DST/SRC/TYPE -> IDLE with frame_abort_o pulse. There is no frame_done_o and frame_len_o is unchanged.
- rx_err: rx_err = 1 with rx_valid in any non-IDLE state -> DROP. This produces a frame_abort_o pulse, and the errored byte is not marked valid.
- DROP: ignores bytes, suppressing valid_o. Returns to IDLE when rx_valid = 0; no second abort pulse.
- Length counter: counts DST through PAY bytes and saturates at all-ones (no wrap). It is cleared on entry to DST.
- Back-to-back frames: a single idle cycle between frames (rx_valid low for 1 cycle) is sufficient. frame_done_o of frame N may coincide with PRE of frame N+1.

Decomposition:
- eth_pkg holds:
  - the PREAMBLE_BYTE (0x55) and SFD_BYTE (0xD5) constants;
  - MAC_ADDR_BYTES = 6 and ETHER_TYPE_BYTES = 2;
  - the state enum fld_state_e {IDLE, PRE, DST, SRC, TYPE, PAY, DROP}.
- Single module, no sub-module. The length counter is inline.

Test Plan:
- 7×0x55, D5, 6 DST, 6 SRC, 08 00, 46 payload+4 FCS, then rx_valid low:
  - flags match each byte position;
  - sof_o pulses once;
  - frame_done_o pulses once, one cycle after the last valid_o;
  - frame_len_o = 64, too_short_o = 0.
- The same frame with 40 payload+FCS bytes -> frame_len_o = 54, too_short_o = 1.
- 8×0x55 then D5 -> frame_abort_o on the 8th 0x55. No valid_o for the remaining bytes, and IDLE after rx_valid falls.
- rx_valid drops after 3 SRC bytes -> frame_abort_o = 1, no frame_done_o, frame_len_o retains the previous value.
- rx_err asserted on payload byte 10 -> frame_abort_o, and valid_o stays 0 from that byte to the end of the frame.
- Two 64-byte frames with a 1-cycle gap -> two frame_done_o pulses, both with frame_len_o = 64. rst_n asserted mid-DST clears all outputs immediately.
